// File: rtl/mul_seq_nxn.sv
// rtl/mul_seq_nxn.sv - sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH
//
// Purpose:
//    Computes a full-precision product over WIDTH iterations of a shift-add
//    loop, using a start/done handshake. A new multiply can be accepted in
//    the DONE cycle, giving one product every WIDTH+1 cycles.
//
// Ports:
//    clk        clock, rising edge
//    rst        synchronous active-high reset
//    start      request a multiply (ignored while busy)
//    a          multiplier, sampled with start
//    b          multiplicand, sampled with start
//    sign_mode  two's-complement operands (only with MUL_SIGNED_EN)
//    busy       multiply in progress
//    done       one-cycle pulse, result valid
//    result     registered product, held until the next completion
//
// Configuration:
//    MUL_SIGNED_EN  when defined, adds sign_mode and signed multiplication.

module mul_seq_nxn #(
   parameter int WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef MUL_SIGNED_EN
   input  logic                 sign_mode,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   // acc[2W] is the carry bit, acc[2W-1:W] the upper half, acc[W-1:0]
   // starts as the multiplier and is consumed one bit per iteration.
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_next;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     upper_sum;
   logic               load;
   logic               last_iter;
   logic               neg;
   logic [WIDTH-1:0]   a_load;
   logic [WIDTH-1:0]   b_load;
   logic               neg_load;

   // Operand conditioning at load time. The signed build loads magnitudes
   // and remembers whether the final product must be negated; the most
   // negative value maps to 2^(WIDTH-1), which still fits unsigned.
`ifdef MUL_SIGNED_EN
   always_comb begin
      a_load   = a;
      b_load   = b;
      neg_load = 1'b0;
      if (sign_mode) begin
         if (a[WIDTH-1]) a_load = ~a + 1'b1;
         if (b[WIDTH-1]) b_load = ~b + 1'b1;
         neg_load = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end
`else
   always_comb begin
      a_load   = a;
      b_load   = b;
      neg_load = 1'b0;
   end
`endif

   // One shift-add step. The carry bit is always 0 before the add because
   // the previous shift moved a zero into it, so the (W+1)-bit sum cannot
   // overflow.
   always_comb begin
      upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
      acc_next  = {1'b0, upper_sum, acc[WIDTH-1:1]};
   end

   assign last_iter = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and handshake outputs; outputs depend on state only.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
            else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         result <= '0;
      end
      else begin
         if (load) begin
            acc   <= {{(WIDTH+1){1'b0}}, a_load};
            mcand <= b_load;
            cnt   <= '0;
            neg   <= neg_load;
         end
         else if (state == RUN) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
         end

         // Result is captured only on the edge that enters DONE.
         if (last_iter) begin
            if (neg) result <= ~acc_next[2*WIDTH-1:0] + 1'b1;
            else     result <= acc_next[2*WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_nxn.sv
// tb/tb_mul_seq_nxn.sv - directed bench for mul_seq_nxn at WIDTH 6 and 8

module tb_mul_seq_nxn;

   logic        clk = 1'b0;
   logic        rst;
   logic        start6, start8;
   logic [5:0]  a6, b6;
   logic [7:0]  a8, b8;
   logic        sm6, sm8;
   logic        busy6, done6, busy8, done8;
   logic [11:0] result6;
   logic [15:0] result8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_seq_nxn #(.WIDTH(6)) dut6 (
      .clk(clk), .rst(rst), .start(start6), .a(a6), .b(b6),
`ifdef MUL_SIGNED_EN
      .sign_mode(sm6),
`endif
      .busy(busy6), .done(done6), .result(result6)
   );

   mul_seq_nxn #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef MUL_SIGNED_EN
      .sign_mode(sm8),
`endif
      .busy(busy8), .done(done8), .result(result8)
   );

   typedef struct {
      logic [5:0]  a;
      logic [5:0]  b;
      logic        sm;
      logic [11:0] exp;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Pulse start, scramble operands afterwards, and check latency, busy
   // length, result and the single-cycle done pulse.
   task automatic mul6(input logic [5:0] ta, input logic [5:0] tb,
                       input logic tsm, input logic [11:0] exp);
      int cyc;
      int nbusy;
      @(negedge clk);
      a6 = ta; b6 = tb; sm6 = tsm; start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0; a6 = ~ta; b6 = ~tb; sm6 = ~tsm;
      cyc = 1; nbusy = 0;
      while (!done6 && cyc < 30) begin
         if (busy6) nbusy++;
         @(negedge clk);
         cyc++;
      end
      check($sformatf("done_seen %0dx%0d", ta, tb), done6, 1);
      check($sformatf("latency %0dx%0d", ta, tb), cyc, 7);
      check($sformatf("busy_len %0dx%0d", ta, tb), nbusy, 6);
      check($sformatf("busy_in_done %0dx%0d", ta, tb), busy6, 0);
      check($sformatf("result %0dx%0d", ta, tb), result6, exp);
      @(negedge clk);
      check($sformatf("done_pulse %0dx%0d", ta, tb), done6, 0);
      check($sformatf("result_hold %0dx%0d", ta, tb), result6, exp);
   endtask

   initial begin
      vec_t vecs[8];
      int cyc, ndone, nbusy, dcyc;

      vecs[0] = '{6'd63, 6'd63, 1'b0, 12'd3969};
      vecs[1] = '{6'd0,  6'd45, 1'b0, 12'd0};
      vecs[2] = '{6'd1,  6'd37, 1'b0, 12'd37};
      vecs[3] = '{6'd5,  6'd6,  1'b0, 12'd30};
      vecs[4] = '{6'd32, 6'd2,  1'b0, 12'd64};
      vecs[5] = '{6'd63, 6'd1,  1'b0, 12'd63};
      vecs[6] = '{6'd42, 6'd21, 1'b0, 12'd882};
      vecs[7] = '{6'd13, 6'd0,  1'b0, 12'd0};

      rst = 1'b1; start6 = 1'b0; start8 = 1'b0;
      a6 = '0; b6 = '0; a8 = '0; b8 = '0; sm6 = 1'b0; sm8 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy6", busy6, 0);
      check("reset done6", done6, 0);
      check("reset result6", result6, 0);
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset result8", result8, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         mul6(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);

      // Ignored start: second request two cycles into the run.
      @(negedge clk);
      a6 = 6'd10; b6 = 6'd12; start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0; a6 = 6'd63; b6 = 6'd63;
      nbusy = busy6 ? 1 : 0;
      @(negedge clk);
      if (busy6) nbusy++;
      start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      ndone = 0; dcyc = 0;
      for (int c = 3; c <= 20; c++) begin
         if (done6) begin
            ndone++;
            dcyc = c;
            check("ignored result", result6, 120);
         end
         if (busy6) nbusy++;
         @(negedge clk);
      end
      check("ignored done_count", ndone, 1);
      check("ignored latency", dcyc, 7);
      check("ignored busy_len", nbusy, 6);

      // Reset during RUN cycle 3.
      @(negedge clk);
      a6 = 6'd50; b6 = 6'd50; start6 = 1'b1;
      @(negedge clk);
      start6 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst busy_before", busy6, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst busy", busy6, 0);
      check("midrst done", done6, 0);
      check("midrst result", result6, 0);
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         if (done6) ndone++;
         @(negedge clk);
      end
      check("midrst no_done", ndone, 0);
      mul6(6'd7, 6'd9, 1'b0, 12'd63);

      // WIDTH=8 back-to-back with start held through the DONE cycle.
      @(negedge clk);
      a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done8 && cyc < 40);
      check("w8 first latency", cyc, 9);
      check("w8 first result", result8, 65025);
      a8 = 8'd200; b8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'd1; b8 = 8'd1;
      check("w8 restart busy", busy8, 1);
      check("w8 restart result_hold", result8, 65025);
      cyc = 1;
      while (!done8 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("w8 done spacing", cyc, 9);
      check("w8 second result", result8, 600);

`ifdef MUL_SIGNED_EN
      mul6(6'b100000, 6'd31, 1'b1, 12'hC20);
      mul6(6'b100000, 6'b100000, 1'b1, 12'h400);
      mul6(6'b111111, 6'b111111, 1'b1, 12'd1);
      mul6(6'd63, 6'd63, 1'b0, 12'd3969);
      mul6(6'd5, 6'b111101, 1'b1, 12'hFF1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
